// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush, bubble-gated control output and a saturating stall counter.
module pipe_stage_reg #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic [CNT_W-1:0]  cnt;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    // Downstream hazard logic must never see a stale control word from a dead entry.
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;
    assign stall_cnt = cnt;

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid;
            logic [DATA_W-1:0] s_data;
            logic [CTRL_W-1:0] s_ctrl;

            // Ready comes straight from a flop, so upstream never sees out_ready combinationally.
            assign in_ready = ~s_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= CTRL_BUBBLE;
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_ctrl  <= CTRL_BUBBLE;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    m_ctrl  <= CTRL_BUBBLE;
                    s_ctrl  <= CTRL_BUBBLE;
                end else if (s_valid) begin
                    if (out_xfer) begin
                        m_data  <= s_data;
                        m_ctrl  <= s_ctrl;
                        s_valid <= 1'b0;
                    end
                end else if (in_xfer) begin
                    if (!m_valid || out_xfer) begin
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                        m_ctrl  <= in_ctrl;
                    end else begin
                        s_valid <= 1'b1;
                        s_data  <= in_data;
                        s_ctrl  <= in_ctrl;
                    end
                end else if (out_xfer) begin
                    m_valid <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready = ~m_valid | out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= CTRL_BUBBLE;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= CTRL_BUBBLE;
                end else if (in_xfer) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                    m_ctrl  <= in_ctrl;
                end else if (out_xfer) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (stall_clr) begin
            cnt <= '0;
        end else if (m_valid && !out_ready && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid instance, single-entry instance, narrow-counter instance.
module tb_pipe_stage_reg;

    logic clk;
    logic reset;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic [15:0]  in_ctrl   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic [15:0]  out_ctrl  [3];
    logic         flush     [3];
    logic         stall_clr [3];
    logic [15:0]  sc0;
    logic [15:0]  sc1;
    logic [3:0]   sc2;

    // Expected-entry queues: stimulus pushes at tail, monitor pops at head.
    logic [143:0] mem  [3][256];
    logic [7:0]   tail [3];
    logic [7:0]   head [3] = '{default: 8'd0};
    logic         acc  [3];
    logic         tmo  [3];
    int           stall_m [3] = '{default: 0};
    logic [7:0]   occ_m;
    logic [143:0] hd_m;
    logic         exp_v;
    logic         exp_r;
    int           n_pass = 0;
    int           n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
        .stall_clr(stall_clr[0]), .stall_cnt(sc0)
    );

    pipe_stage_reg #(.SKID(0), .CTRL_BUBBLE(16'h00F0)) u_single (
        .clk(clk), .reset(reset), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
        .stall_clr(stall_clr[1]), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_ctrl(in_ctrl[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_ctrl(out_ctrl[2]),
        .stall_clr(stall_clr[2]), .stall_cnt(sc2)
    );

    function automatic logic [15:0] bubble(input int k);
        return (k == 1) ? 16'h00F0 : 16'h0000;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] sc(input int k);
        if (k == 0) return sc0;
        if (k == 1) return sc1;
        return {12'd0, sc2};
    endfunction

    task automatic chk(input int k, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    endtask

    // Monitor: sampled between the input drive point and the next rising edge.
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                chk(k, "rst_out_valid", 128'(out_valid[k]), 128'(0));
                chk(k, "rst_out_ctrl", 128'(out_ctrl[k]), 128'(bubble(k)));
                chk(k, "rst_out_data", out_data[k], 128'(0));
                chk(k, "rst_stall_cnt", 128'(sc(k)), 128'(0));
                head[k]    = tail[k];
                stall_m[k] = 0;
            end else begin
                occ_m = tail[k] - head[k];
                exp_v = (occ_m != 8'd0);
                exp_r = (k == 1) ? ((occ_m == 8'd0) || out_ready[k]) : (occ_m < 8'd2);
                chk(k, "out_valid", 128'(out_valid[k]), 128'(exp_v));
                chk(k, "in_ready", 128'(in_ready[k]), 128'(exp_r));
                if (!exp_v) chk(k, "bubble_ctrl", 128'(out_ctrl[k]), 128'(bubble(k)));
                chk(k, "stall_cnt", 128'(sc(k)), 128'(stall_m[k]));
                chk(k, "accept_timeout", 128'(tmo[k]), 128'(0));
                if (flush[k]) begin
                    head[k] = tail[k];
                end else if (exp_v && out_ready[k]) begin
                    hd_m = mem[k][head[k]];
                    chk(k, "out_data", out_data[k], hd_m[127:0]);
                    chk(k, "out_ctrl", 128'(out_ctrl[k]), 128'(hd_m[143:128]));
                    head[k] = head[k] + 8'd1;
                end
                if (stall_clr[k]) stall_m[k] = 0;
                else if (exp_v && !out_ready[k] && stall_m[k] < cnt_max(k)) stall_m[k]++;
            end
        end
    end

    // Called at a falling edge with inputs already set; records accepted entries, returns at next falling edge.
    task automatic tick();
        #3;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 1'b0;
            if (!reset && !flush[k] && in_valid[k] && in_ready[k]) begin
                mem[k][tail[k]] = {in_ctrl[k], in_data[k]};
                tail[k] = tail[k] + 8'd1;
                acc[k] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_wait(input int k);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc[k] && n < 20);
        if (!acc[k]) tmo[k] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            flush[k]     = 1'b0;
            stall_clr[k] = 1'b0;
            in_data[k]   = '0;
            in_ctrl[k]   = 16'h000A;
            tail[k]      = 8'd0;
            acc[k]       = 1'b0;
            tmo[k]       = 1'b0;
        end
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Streaming with out_ready high
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 128'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        repeat (2) tick();

        // Backpressure into the skid entry
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 128'h11; tick();
        in_data[0]   = 128'h22; tick();
        in_data[0]   = 128'h33; repeat (3) tick();
        out_ready[0] = 1'b1;
        send_wait(0);
        in_valid[0]  = 1'b0;
        repeat (4) tick();

        // Flush with both entries full, then with only M full and input accepted
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 128'h44; tick();
        in_data[0]   = 128'h55; tick();
        in_data[0]   = 128'h66; flush[0] = 1'b1; tick();
        flush[0]     = 1'b0; in_valid[0] = 1'b0; tick();
        in_valid[0]  = 1'b1;
        in_data[0]   = 128'h77; tick();
        in_data[0]   = 128'h88; flush[0] = 1'b1; tick();
        flush[0]     = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        repeat (3) tick();

        // Single-entry: blocked ready, then replace in one edge
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 128'hA1; tick();
        in_data[1]   = 128'hA2; repeat (2) tick();
        out_ready[1] = 1'b1; tick();
        in_data[1]   = 128'hA3; tick();
        in_data[1]   = 128'hA4; tick();
        in_valid[1]  = 1'b0;
        repeat (2) tick();

        // Counter saturation and clear while stalled
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_data[2]   = 128'hB1; tick();
        in_valid[2]  = 1'b0;
        repeat (20) tick();
        stall_clr[2] = 1'b1; tick();
        stall_clr[2] = 1'b0; repeat (2) tick();
        out_ready[2] = 1'b1; repeat (2) tick();

        // Reset while M and S are both valid
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 128'hC1; tick();
        in_data[0]   = 128'hC2; tick();
        in_valid[0]  = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        out_ready[0] = 1'b1; tick();

        // Randomised traffic on all three instances
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
                in_ctrl[k]   = 16'($urandom);
                out_ready[k] = ($urandom_range(0, 9) < 7);
                flush[k]     = ($urandom_range(0, 29) == 0);
                stall_clr[k] = ($urandom_range(0, 39) == 0);
            end
            tick();
        end

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            flush[k]     = 1'b0;
            stall_clr[k] = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; the successor to the fixed per-stage registers between ID/EX, EX/MEM and MEM/WB.
- Carries a wide data bundle and a control bundle under a valid/ready handshake, with an optional skid buffer, synchronous flush, bubble insertion and a saturating stall counter.
- Sits between two pipeline stages. The upstream stage drives in_*; the downstream stage consumes out_*.

Parameters:
DATA_W, 128, width of data bundle (PC, operands, immediate, register indices)
CTRL_W, 16, width of control bundle (RegWr, Mem_wr, Branch, ALUOp, ...)
CTRL_BUBBLE, 0, control value presented when no valid instruction is held (must decode as a NOP)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  stage presents a valid instruction
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  presented data bundle
out_ctrl  out  CTRL_W  presented control; equals CTRL_BUBBLE whenever out_valid=0
stall_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - No combinational path from in_valid to out_valid (minimum latency 1 cycle).
- Reset (asynchronous):
  - All valid bits 0, in_ready=1, out_valid=0.
  - out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0.
- Entries:
  - Main register (M) drives out_*.
  - Skid register (S) exists only when SKID=1.
- SKID=0:
  - in_ready = ~M.valid | out_ready (combinational).
  - M loads on input transfer.
  - M.valid clears on output transfer without input transfer.
- SKID=1:
  - in_ready = ~S.valid, registered; no combinational ready path.
  - Empty M: input loads M.
  - M valid, output transfer, input transfer: input loads M.
  - M valid, no output transfer, input transfer: input loads S. in_ready drops next cycle.
  - S valid, output transfer: S moves into M, S.valid=0, in_ready=1 next cycle.
  - Order is preserved; no entry is ever dropped or duplicated.
- Throughput: with out_ready held at 1, one instruction per cycle for both SKID values.
- Flush (synchronous, highest priority below reset):
  - Next edge: M.valid=0, S.valid=0.
  - Any input transfer in the same cycle is discarded.
  - Data registers hold their value (no clear needed).
  - The control registers load CTRL_BUBBLE.
- out_ctrl gating: out_ctrl = M.valid ? M.ctrl : CTRL_BUBBLE. This guarantees hazard/forwarding logic never sees stale RegWr or Mem_wr.
- Hold: with out_valid=1 and out_ready=0, out_data and out_ctrl are stable until transfer or flush.
- stall_cnt:
  - Increments each cycle out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr has priority over increment: counter goes to 0 that cycle.
  - Not affected by flush.
- Simultaneous events:
  - reset overrides all.
  - flush overrides transfers.
  - stall_clr and flush are independent.

Test Plan:
- Reset mid-stream: assert reset while M and S are valid (SKID=1) → same cycle out_valid=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0; in_ready=1 after deassert.
- Streaming, SKID=1, out_ready=1: push data 0x1..0x8, ctrl 0x0A → out_data 0x1..0x8 on 8 consecutive cycles, one cycle after input, ctrl 0x0A each.
- Backpressure: hold out_ready=0 while pushing 0x11, 0x22, 0x33 →
  - 0x11 held on output, 0x22 in skid.
  - in_ready=0 one cycle after 0x22 is accepted; 0x33 not accepted.
  - Release out_ready: outputs 0x11, 0x22, 0x33 in order.
  - stall_cnt equals the number of blocked cycles.
- Flush with simultaneous input: M=0x44, S=0x55, in_valid=1 data 0x66, flush=1 →
  - Next cycle out_valid=0, out_ctrl=CTRL_BUBBLE.
  - 0x66 is never output.
- SKID=0 instance: out_ready=0 with M valid → in_ready=0 combinationally; raising out_ready the same cycle with in_valid=1 → replace in one edge, no bubble.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt=15; pulse stall_clr while still stalled → 0 next cycle, then 1.
